// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-port integer register file for the RISC-V pipeline. It sits between
// decode (reads), issue (destination reservation) and write-back (writes).
// Entry 0 is hardwired to zero. After reset a clear sequencer zeroes every
// entry, one per clock, before the file reports ready. A per-entry busy
// scoreboard marks destinations that have been issued but not yet written back.
//
// Optional feature: define REGFILE_BYPASS_EN to forward a write-back to a read
// of the same index in the same cycle (data and busy).
//
// Parameters
//   WIDTH       data width of each entry
//   DEPTH_LOG2  address width; the file holds 2**DEPTH_LOG2 entries
//   NREAD       number of combinational read ports
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset, restarts the clear sequence
//   regWrite   write-back enable
//   writeReg   write-back address
//   dataWrite  write-back data
//   readReg    read addresses, port i at [i*DEPTH_LOG2 +: DEPTH_LOG2]
//   readData   read data, port i at [i*WIDTH +: WIDTH]
//   readBusy   per-port scoreboard bit of the addressed entry
//   issueValid issue stage reserves a destination
//   issueReg   destination being reserved
//   ready      clear sequence finished, file accepts reads and writes
module regfile_mp #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 5,
  parameter int NREAD      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        regWrite,
  input  logic [DEPTH_LOG2-1:0]       writeReg,
  input  logic [WIDTH-1:0]            dataWrite,
  input  logic [NREAD*DEPTH_LOG2-1:0] readReg,
  output logic [NREAD*WIDTH-1:0]      readData,
  output logic [NREAD-1:0]            readBusy,
  input  logic                        issueValid,
  input  logic [DEPTH_LOG2-1:0]       issueReg,
  output logic                        ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] IDX_LAST = '1;

  typedef enum logic {
    CLEAR,
    RUN
  } stateType;

  stateType                state;
  stateType                stateNext;
  logic [DEPTH_LOG2-1:0]   clearIdx;
  logic [DEPTH_LOG2-1:0]   clearIdxNext;
  logic [WIDTH-1:0]        mem [DEPTH];
  logic [DEPTH-1:0]        busy;
  logic [DEPTH-1:0]        busyNext;
  logic                    writeEn;
  logic                    issueEn;
  logic [DEPTH_LOG2-1:0]   readAddr [NREAD];

  // Unpack the flat read-address bus into one address per port.
  for (genvar g = 0; g < NREAD; g++) begin : gUnpack
    assign readAddr[g] = readReg[g*DEPTH_LOG2 +: DEPTH_LOG2];
  end

  // State register: the sequencer state and the clear index restart together
  // on reset, so a reset in the middle of clearing starts again from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clearIdx <= '0;
    end else begin
      state    <= stateNext;
      clearIdx <= clearIdxNext;
    end
  end

  // Next-state logic: walk the clear index across every entry once, then
  // settle in RUN. The edge that clears the last entry is the one that leaves.
  always_comb begin
    stateNext    = state;
    clearIdxNext = clearIdx;
    if (state == CLEAR) begin
      clearIdxNext = clearIdx + IDX_ONE;
      if (clearIdx == IDX_LAST) begin
        stateNext = RUN;
      end
    end
  end

  // Output logic: write-back and issue are only honoured in RUN, and both
  // ignore entry 0 so it can never hold data or look busy.
  always_comb begin
    ready   = (state == RUN);
    writeEn = (state == RUN) && regWrite   && (writeReg != '0);
    issueEn = (state == RUN) && issueValid && (issueReg != '0);
  end

  // Storage array. It carries no reset of its own; the clear sequencer is what
  // zeroes it, which keeps the array mappable onto plain RAM-style flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clearIdx] <= '0;
      end else if (writeEn) begin
        mem[writeReg] <= dataWrite;
      end
    end
  end

  // Scoreboard update. The issue is applied after the write so that a
  // same-edge write and issue to one index leaves the bit set.
  always_comb begin
    busyNext = busy;
    if (writeEn) begin
      busyNext[writeReg] = 1'b0;
    end
    if (issueEn) begin
      busyNext[issueReg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busyNext;
    end
  end

  // Read ports: purely combinational. Everything reads as zero while clearing
  // and for entry 0; with forwarding enabled a matching write-back wins over
  // the stored value and reports the entry as no longer busy.
  always_comb begin
    readData = '0;
    readBusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if ((state == RUN) && (readAddr[i] != '0)) begin
        readData[i*WIDTH +: WIDTH] = mem[readAddr[i]];
        readBusy[i]                = busy[readAddr[i]];
`ifdef REGFILE_BYPASS_EN
        if (writeEn && (writeReg == readAddr[i])) begin
          readData[i*WIDTH +: WIDTH] = dataWrite;
          readBusy[i]                = 1'b0;
        end
`else
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Directed bench for regfile_mp with the default parameters (64-bit, 32
// entries, 2 read ports). Expected values are written out by hand for each
// vector. The same-cycle read-after-write vector follows REGFILE_BYPASS_EN.
module tb_regfile_mp;

  localparam int WIDTH      = 64;
  localparam int DEPTH_LOG2 = 5;
  localparam int NREAD      = 2;

  logic                        clk;
  logic                        rst;
  logic                        regWrite;
  logic [DEPTH_LOG2-1:0]       writeReg;
  logic [WIDTH-1:0]            dataWrite;
  logic [NREAD*DEPTH_LOG2-1:0] readReg;
  logic [NREAD*WIDTH-1:0]      readData;
  logic [NREAD-1:0]            readBusy;
  logic                        issueValid;
  logic [DEPTH_LOG2-1:0]       issueReg;
  logic                        ready;

  int compared   = 0;
  int mismatched = 0;

  regfile_mp #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .NREAD      (NREAD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .regWrite   (regWrite),
    .writeReg   (writeReg),
    .dataWrite  (dataWrite),
    .readReg    (readReg),
    .readData   (readData),
    .readBusy   (readBusy),
    .issueValid (issueValid),
    .issueReg   (issueReg),
    .ready      (ready)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 unit past it, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the write-back and issue ports for the next edge.
  task automatic applyStimulus(input logic we, input logic [4:0] wa,
                               input logic [63:0] wd, input logic iv,
                               input logic [4:0] ia);
    regWrite   = we;
    writeReg   = wa;
    dataWrite  = wd;
    issueValid = iv;
    issueReg   = ia;
  endtask

  task automatic setReads(input logic [4:0] a0, input logic [4:0] a1);
    readReg = {a1, a0};
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    readReg = '0;

    // Reset held for two edges.
    tick();
    tick();
    setReads(5'd1, 5'd2);
    checkOutput("reset_ready", {63'h0, ready}, 64'h0);
    checkOutput("reset_data0", readData[63:0], 64'h0);
    checkOutput("reset_data1", readData[127:64], 64'h0);
    checkOutput("reset_busy", {62'h0, readBusy}, 64'h0);

    // Clear sequence; write-back and issue are driven but must be ignored.
    rst = 1'b0;
    applyStimulus(1'b1, 5'd5, 64'hCAFE_0000_0000_0005, 1'b1, 5'd5);
    for (int k = 0; k < 32; k++) begin
      tick();
      checkOutput($sformatf("clear_ready_e%0d", k), {63'h0, ready},
                  (k == 31) ? 64'h1 : 64'h0);
      if (k == 20) begin
        checkOutput("clear_data_zero", readData[63:0], 64'h0);
      end
    end
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);

    // Every entry reads zero and not busy after clearing.
    for (int i = 0; i < 32; i++) begin
      setReads(i[4:0], 5'(31 - i));
      checkOutput($sformatf("cleared_p0_x%0d", i), readData[63:0], 64'h0);
      checkOutput($sformatf("cleared_p1_x%0d", 31 - i), readData[127:64], 64'h0);
      checkOutput($sformatf("cleared_busy_x%0d", i), {62'h0, readBusy}, 64'h0);
    end

    // Write and read back on both ports.
    applyStimulus(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    setReads(5'd5, 5'd5);
    checkOutput("x5_p0", readData[63:0], 64'hDEAD_BEEF_0000_0001);
    checkOutput("x5_p1", readData[127:64], 64'hDEAD_BEEF_0000_0001);
    checkOutput("x5_busy", {62'h0, readBusy}, 64'h0);

    // Entry 0 protection against write and issue.
    applyStimulus(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    setReads(5'd0, 5'd0);
    checkOutput("x0_data", readData[63:0], 64'h0);
    checkOutput("x0_busy", {62'h0, readBusy}, 64'h0);

    // Scoreboard: issue x7, write it back two cycles later.
    setReads(5'd7, 5'd0);
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd7);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    checkOutput("x7_busy_c1", {62'h0, readBusy}, 64'h1);
    tick();
    checkOutput("x7_busy_c2", {62'h0, readBusy}, 64'h1);
    applyStimulus(1'b1, 5'd7, 64'h77, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    checkOutput("x7_busy_done", {62'h0, readBusy}, 64'h0);
    checkOutput("x7_data", readData[63:0], 64'h77);

    // Same-edge issue and write to x9: data lands, busy stays set.
    applyStimulus(1'b1, 5'd9, 64'h12, 1'b1, 5'd9);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    setReads(5'd9, 5'd10);
    checkOutput("x9_data", readData[63:0], 64'h12);
    checkOutput("x9_busy", {62'h0, readBusy}, 64'h1);

    // Write x9 and issue x10 on one edge: independent effects.
    applyStimulus(1'b1, 5'd9, 64'h34, 1'b1, 5'd10);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    checkOutput("x9_data2", readData[63:0], 64'h34);
    checkOutput("x9x10_busy", {62'h0, readBusy}, 64'h2);

    // Re-issue of a busy entry does not count; one write clears it.
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd10);
    tick();
    checkOutput("x10_reissue", {62'h0, readBusy}, 64'h2);
    applyStimulus(1'b1, 5'd10, 64'hA0, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    checkOutput("x10_cleared", {62'h0, readBusy}, 64'h0);
    checkOutput("x10_data", readData[127:64], 64'hA0);

    // Same-cycle read of the write address x3 (x3 holds 0x11 and is busy).
    applyStimulus(1'b1, 5'd3, 64'h11, 1'b1, 5'd3);
    tick();
    applyStimulus(1'b1, 5'd3, 64'h55, 1'b0, 5'd0);
    setReads(5'd3, 5'd3);
`ifdef REGFILE_BYPASS_EN
    checkOutput("x3_same_cycle", readData[63:0], 64'h55);
    checkOutput("x3_same_busy", {62'h0, readBusy}, 64'h0);
`else
    checkOutput("x3_same_cycle", readData[63:0], 64'h11);
    checkOutput("x3_same_busy", {62'h0, readBusy}, 64'h3);
`endif
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    checkOutput("x3_next_cycle", readData[127:64], 64'h55);
    checkOutput("x3_next_busy", {62'h0, readBusy}, 64'h0);

    // Reset in the middle of RUN.
    applyStimulus(1'b1, 5'd4, 64'hAA, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd6);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    setReads(5'd4, 5'd6);
    checkOutput("x4_before_rst", readData[63:0], 64'hAA);
    checkOutput("x6_busy_before_rst", {62'h0, readBusy}, 64'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_run_ready", {63'h0, ready}, 64'h0);
    checkOutput("rst_run_data", readData[63:0], 64'h0);
    for (int k = 0; k < 31; k++) begin
      tick();
    end
    checkOutput("rerun_ready_e30", {63'h0, ready}, 64'h0);
    tick();
    checkOutput("rerun_ready_e31", {63'h0, ready}, 64'h1);
    checkOutput("rerun_x4_zero", readData[63:0], 64'h0);
    checkOutput("rerun_x6_busy", {62'h0, readBusy}, 64'h0);
    setReads(5'd5, 5'd9);
    checkOutput("rerun_x5_zero", readData[63:0], 64'h0);
    checkOutput("rerun_x9_zero", readData[127:64], 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V pipeline, sitting between decode (reads), issue (destination reservation) and write-back (writes). It has N combinational read ports, one clocked write port, and a hardwired-zero entry 0. A post-reset clear sequencer zeroes every entry, and a per-entry busy scoreboard lets decode detect pending write-backs. Optional write-to-read bypass is compiled in by macro.

## Interface
- WIDTH, 64, data width of each entry
- DEPTH_LOG2, 5, address width; the file has 2**DEPTH_LOG2 entries
- NREAD, 2, number of read ports
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- regWrite  in  1  write enable from write-back
- writeReg  in  DEPTH_LOG2  write address
- dataWrite  in  WIDTH  write data
- readReg  in  NREAD*DEPTH_LOG2  read addresses; port i at bits [i*DEPTH_LOG2 +: DEPTH_LOG2]
- readData  out  NREAD*WIDTH  read data; port i at bits [i*WIDTH +: WIDTH]
- readBusy  out  NREAD  port i address has a pending write (scoreboard bit)
- issueValid  in  1  issue stage reserves a destination
- issueReg  in  DEPTH_LOG2  destination being reserved
- ready  out  1  clear sequence done; file accepts reads and writes

## Operation
- Two states: CLEAR and RUN. rst forces CLEAR with clear index 0, ready=0, and all busy bits 0.
- CLEAR: each edge writes 0 to the entry at the clear index, then increments the index. The edge that clears entry 2**DEPTH_LOG2-1 moves to RUN and sets ready=1.
- While in CLEAR, regWrite and issueValid are ignored, and all readData and readBusy outputs are 0.
- RUN write: on an edge with regWrite=1 and writeReg!=0, the entry at writeReg takes dataWrite and its busy bit is cleared. Writes to entry 0 are dropped.
- RUN reads: combinational. readData[i] is the array content, or 0 if readReg[i]==0. readBusy[i] is the busy bit, and is always 0 for entry 0.
- Issue: on an edge with issueValid=1 and issueReg!=0, the busy bit of issueReg is set.
- Same-edge write and issue to the same index: the entry takes dataWrite and the busy bit ends up set (issue wins).
- Different indices: both actions take effect independently.
- Issue to an already-busy entry: the bit stays set. There is no counting; one write clears it.
- rst asserted during RUN or mid-CLEAR: restart CLEAR from index 0 on the next edge. All data is re-zeroed and ready drops to 0.

## Timing
- Reset values: ready=0, readData=0 on all ports, readBusy=0 on all ports.
- Clear latency: counting the first edge with rst=0 as edge 0, ready is high after edge 2**DEPTH_LOG2-1. That is 32 edges for the default.
- Write-to-read latency without bypass: new data is visible on readData after the write edge. In the write cycle itself the old value is returned.
- Busy: set/clear visible on readBusy immediately after the edge. There is no same-cycle bypass of busy.
- Reads have zero latency: purely combinational from readReg and state.

## Configuration
- REGFILE_BYPASS_EN defined: in RUN, if regWrite=1, writeReg!=0 and writeReg==readReg[i], then in the same cycle readData[i]=dataWrite and readBusy[i]=0. This is write-first forwarding.
- REGFILE_BYPASS_EN undefined: no forwarding. Same-cycle reads return the stored value and the stored busy bit.
- Either way, entry 0 reads 0 and there is no forwarding during CLEAR.

## Test plan
- Clear sequence: assert rst for 2 cycles, then release. Required: ready=0 for 31 edges and ready=1 after edge 31. All 32 entries read 0 and readBusy=0.
- Write and read back: write 0xDEAD_BEEF_0000_0001 to x5, then read x5 on port 0 and x5 on port 1 the next cycle. Required: both return the value and readBusy=0.
- x0 protection: write 0xFFFF_FFFF_FFFF_FFFF to x0 with issueValid=1 and issueReg=0. Required: x0 reads 0 and readBusy=0.
- Scoreboard: issue x7, then write x7 two cycles later. Required: readBusy is 1 for 2 cycles, then 0. Same-edge issue x9 plus write x9 with 0x12: required data 0x12 and busy=1.
- Same-cycle read of write address x3 with 0x55:
  - with REGFILE_BYPASS_EN defined: required 0x55 that cycle;
  - with it undefined: required the old value, then 0x55 the next cycle.
- Reset mid-RUN: write x4=0xAA, issue x6, then assert rst for 1 cycle. Required: ready=0, and after 32 edges x4 reads 0 and x6 busy=0.
